// File: rtl/jb_predict_if.sv
// Fetch/execute bus of the jump/branch resolution unit.
// The requester drives predict/resolve inputs; the unit answers with selects and stats.
interface jb_predict_if #(
  parameter int STAT_W = 32
);
  logic              fetch_valid;
  logic [31:0]       fetch_pc;
  logic              pred_taken;
  logic              ex_valid;
  logic              ex_stall;
  logic [31:0]       ex_pc;
  logic [3:0]        ex_jb;
  logic [31:0]       ex_alu_out;
  logic              ex_alu_zero;
  logic              ex_pred_taken;
  logic [1:0]        jump_sel;
  logic              mispredict;
  logic [STAT_W-1:0] branch_count;
  logic [STAT_W-1:0] mispredict_count;

  modport master (
    output fetch_valid, fetch_pc, ex_valid, ex_stall, ex_pc, ex_jb,
           ex_alu_out, ex_alu_zero, ex_pred_taken,
    input  pred_taken, jump_sel, mispredict, branch_count, mispredict_count
  );

  modport slave (
    input  fetch_valid, fetch_pc, ex_valid, ex_stall, ex_pc, ex_jb,
           ex_alu_out, ex_alu_zero, ex_pred_taken,
    output pred_taken, jump_sel, mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/jb_predict_unit.sv
// Jump/branch resolver with a BHT of saturating counters: predicts at fetch,
// resolves at execute, trains the table and counts branches/mispredicts.
module jb_predict_unit #(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_W       = 6,
  parameter int CNT_W       = 2,
  parameter int STAT_W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  jb_predict_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  localparam logic [3:0] JB_J    = 4'b0001;
  localparam logic [3:0] JB_JR   = 4'b0010;
  localparam logic [3:0] JB_BEQ  = 4'b0011;
  localparam logic [3:0] JB_BNE  = 4'b0100;
  localparam logic [3:0] JB_BLEZ = 4'b0101;
  localparam logic [3:0] JB_BGTZ = 4'b0110;
  localparam logic [3:0] JB_BLTZ = 4'b0111;
  localparam logic [3:0] JB_BGEZ = 4'b1000;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  bht_q [BHT_ENTRIES];
  logic [CNT_W-1:0]  bht_d [BHT_ENTRIES];
  logic [STAT_W-1:0] branch_count_q, branch_count_d;
  logic [STAT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic             act, cond, lt, taken, mispredict;
  logic [1:0]       jump_sel;
  logic [IDX_W-1:0] fetch_idx, ex_idx;
  logic             unused_pc_bits;

  assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
  assign ex_idx    = bus.ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.fetch_pc[31:IDX_W+2], bus.fetch_pc[1:0],
                            bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};

  // Resolution is gated by rst_n so nothing leaks out while reset is held.
  always_comb begin
    lt         = (bus.ex_alu_out == 32'd1);
    act        = rst_n & bus.ex_valid & ~bus.ex_stall;
    cond       = 1'b0;
    taken      = 1'b0;
    jump_sel   = 2'b00;
    unique case (bus.ex_jb)
      JB_BEQ:  begin cond = act; taken = bus.ex_alu_zero;        end
      JB_BNE:  begin cond = act; taken = ~bus.ex_alu_zero;       end
      JB_BLEZ: begin cond = act; taken = lt | bus.ex_alu_zero;   end
      JB_BGTZ: begin cond = act; taken = ~lt & ~bus.ex_alu_zero; end
      JB_BLTZ: begin cond = act; taken = lt;                     end
      JB_BGEZ: begin cond = act; taken = ~lt;                    end
      default: ;
    endcase
    if (act && bus.ex_jb == JB_J)       jump_sel = 2'b10;
    else if (act && bus.ex_jb == JB_JR) jump_sel = 2'b11;
    else if (cond && taken)             jump_sel = 2'b01;
    mispredict = cond & (taken != bus.ex_pred_taken);
  end

  always_comb begin
    bht_d              = bht_q;
    branch_count_d     = branch_count_q + STAT_W'(cond);
    mispredict_count_d = mispredict_count_q + STAT_W'(mispredict);
    if (cond) begin
      bht_d[ex_idx] = taken ? sat_inc(bht_q[ex_idx]) : sat_dec(bht_q[ex_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bht_q              <= '{default: CNT_INIT};
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Fetch reads the registered table, so a same-cycle update shows up next cycle.
  assign bus.pred_taken       = rst_n & bus.fetch_valid & bht_q[fetch_idx][CNT_W-1];
  assign bus.jump_sel         = jump_sel;
  assign bus.mispredict       = mispredict;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_jb_predict_unit.sv
// Directed bench for jb_predict_unit: vector table for resolution plus
// hand sequences for training, stall, counter wrap and mid-stream reset.
module tb_jb_predict_unit;
  localparam int STAT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jb_predict_if #(.STAT_W(STAT_W)) bus ();

  jb_predict_unit #(.BHT_ENTRIES(64), .IDX_W(6), .CNT_W(2), .STAT_W(STAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [STAT_W-1:0] exp_bc = '0;
  logic [STAT_W-1:0] exp_mc = '0;

  typedef struct {
    logic        valid;
    logic        stall;
    logic [3:0]  jb;
    logic [31:0] alu;
    logic        zero;
    logic        pred;
    logic [1:0]  exp_sel;
    logic        exp_mp;
    logic        exp_cond;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ex(input logic valid, input logic stall, input logic [3:0] jb,
                        input logic [31:0] pc, input logic [31:0] alu,
                        input logic zero, input logic pred);
    bus.ex_valid      = valid;
    bus.ex_stall      = stall;
    bus.ex_jb         = jb;
    bus.ex_pc         = pc;
    bus.ex_alu_out    = alu;
    bus.ex_alu_zero   = zero;
    bus.ex_pred_taken = pred;
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string name);
    chk({name, "_bc"}, 32'(bus.branch_count), 32'(exp_bc));
    chk({name, "_mc"}, 32'(bus.mispredict_count), 32'(exp_mc));
  endtask

  task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    #1;
    chk(name, 32'(bus.pred_taken), 32'(exp));
  endtask

  // Resolve one conditional branch at pc, then advance one edge.
  task automatic branch(input logic [3:0] jb, input logic [31:0] pc,
                        input logic zero, input logic [31:0] alu, input logic pred,
                        input logic tk);
    set_ex(1'b1, 1'b0, jb, pc, alu, zero, pred);
    tick();
    exp_bc = exp_bc + 1'b1;
    if (tk != pred) exp_mc = exp_mc + 1'b1;
    idle();
  endtask

  initial begin
    // valid stall jb alu zero pred | sel mp cond
    vecs.push_back('{1, 0, 4'b0001, 32'd0, 0, 0, 2'b10, 0, 0});
    vecs.push_back('{1, 0, 4'b0010, 32'd0, 0, 0, 2'b11, 0, 0});
    vecs.push_back('{1, 0, 4'b1011, 32'd0, 1, 0, 2'b00, 0, 0});
    vecs.push_back('{1, 0, 4'b0000, 32'd0, 1, 1, 2'b00, 0, 0});
    vecs.push_back('{0, 0, 4'b0001, 32'd0, 0, 0, 2'b00, 0, 0});
    vecs.push_back('{1, 0, 4'b0100, 32'd0, 0, 1, 2'b01, 0, 1});
    vecs.push_back('{1, 0, 4'b0100, 32'd0, 1, 1, 2'b00, 1, 1});
    vecs.push_back('{1, 0, 4'b0101, 32'd1, 0, 0, 2'b01, 1, 1});
    vecs.push_back('{1, 0, 4'b0101, 32'd0, 1, 1, 2'b01, 0, 1});
    vecs.push_back('{1, 0, 4'b0101, 32'd0, 0, 0, 2'b00, 0, 1});
    vecs.push_back('{1, 0, 4'b0110, 32'd0, 0, 1, 2'b01, 0, 1});
    vecs.push_back('{1, 0, 4'b0110, 32'd1, 0, 1, 2'b00, 1, 1});
    vecs.push_back('{1, 0, 4'b0111, 32'd1, 0, 0, 2'b01, 1, 1});
    vecs.push_back('{1, 0, 4'b0111, 32'd2, 0, 0, 2'b00, 0, 1});
    vecs.push_back('{1, 0, 4'b1000, 32'd0, 0, 0, 2'b01, 1, 1});
    vecs.push_back('{1, 0, 4'b1000, 32'd1, 0, 0, 2'b00, 0, 1});
    vecs.push_back('{1, 0, 4'b0011, 32'd0, 0, 0, 2'b00, 0, 1});
    vecs.push_back('{1, 1, 4'b0010, 32'd0, 0, 0, 2'b00, 0, 0});
    vecs.push_back('{1, 0, 4'b1111, 32'd1, 1, 0, 2'b00, 0, 0});
    vecs.push_back('{1, 1, 4'b0011, 32'd0, 1, 0, 2'b00, 0, 0});

    rst_n = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h40;
    set_ex(1'b1, 1'b0, 4'b0001, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    chk("rst_jump_sel", 32'(bus.jump_sel), 32'd0);
    chk("rst_pred", 32'(bus.pred_taken), 32'd0);
    set_ex(1'b1, 1'b0, 4'b0011, 32'h40, 32'h0, 1'b1, 1'b0);
    #1;
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    idle();
    rst_n = 1'b1;
    #1;
    check_counts("reset");
    check_pred("reset_pred_40", 32'h40, 1'b0);
    check_pred("reset_pred_1c", 32'h1c, 1'b0);
    chk("reset_jump_sel", 32'(bus.jump_sel), 32'd0);

    // BEQ taken at 0x40 with stale not-taken prediction.
    bus.fetch_pc = 32'h40;
    set_ex(1'b1, 1'b0, 4'b0011, 32'h40, 32'h0, 1'b1, 1'b0);
    #1;
    chk("beq_jump_sel", 32'(bus.jump_sel), 32'd1);
    chk("beq_mispredict", 32'(bus.mispredict), 32'd1);
    chk("beq_same_cycle_pred", 32'(bus.pred_taken), 32'd0);
    tick();
    exp_bc = 1; exp_mc = 1;
    idle();
    check_counts("beq");
    check_pred("beq_pred_40", 32'h40, 1'b1);
    bus.fetch_valid = 1'b0;
    #1;
    chk("pred_fetch_invalid", 32'(bus.pred_taken), 32'd0);

    // Idx 5: counter 1 -> 2 -> 3 -> 3 -> 3, then 2 (pred 1), then 1 (pred 0).
    for (int i = 0; i < 4; i++) branch(4'b0011, 32'h14, 1'b1, 32'h0, 1'b1, 1'b1);
    check_pred("train_sat_pred", 32'h14, 1'b1);
    branch(4'b0011, 32'h14, 1'b0, 32'h0, 1'b1, 1'b0);
    check_pred("train_nt1_pred", 32'h14, 1'b1);
    branch(4'b0011, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0);
    check_pred("train_nt2_pred", 32'h14, 1'b0);
    check_counts("train");

    foreach (vecs[i]) begin
      set_ex(vecs[i].valid, vecs[i].stall, vecs[i].jb, 32'h80, vecs[i].alu,
             vecs[i].zero, vecs[i].pred);
      #1;
      chk($sformatf("vec%0d_jump_sel", i), 32'(bus.jump_sel), 32'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_mispredict", i), 32'(bus.mispredict), 32'(vecs[i].exp_mp));
      tick();
      if (vecs[i].exp_cond) exp_bc = exp_bc + 1'b1;
      if (vecs[i].exp_mp)   exp_mc = exp_mc + 1'b1;
      check_counts($sformatf("vec%0d", i));
    end
    idle();

    // Stalled BLTZ at idx 5 (counter 1): no effect until the stall drops.
    set_ex(1'b1, 1'b1, 4'b0111, 32'h14, 32'd1, 1'b0, 1'b0);
    #1;
    chk("stall_jump_sel", 32'(bus.jump_sel), 32'd0);
    chk("stall_mispredict", 32'(bus.mispredict), 32'd0);
    tick();
    check_counts("stall");
    check_pred("stall_pred", 32'h14, 1'b0);
    bus.ex_stall = 1'b0;
    #1;
    chk("unstall_jump_sel", 32'(bus.jump_sel), 32'd1);
    chk("unstall_mispredict", 32'(bus.mispredict), 32'd1);
    tick();
    exp_bc = exp_bc + 1'b1;
    exp_mc = exp_mc + 1'b1;
    idle();
    check_counts("unstall");
    check_pred("unstall_pred", 32'h14, 1'b1);

    // Run branch_count up to all-ones, then one more BNE wraps it to zero.
    for (int i = 0; i < 16 && exp_bc != 4'hF; i++)
      branch(4'b0100, 32'hC0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_full", 32'(bus.branch_count), 32'hF);
    branch(4'b0100, 32'hC0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_zero", 32'(bus.branch_count), 32'h0);
    check_counts("wrap");

    // Reset while a branch is resolving discards the update and re-inits the table.
    rst_n = 1'b0;
    set_ex(1'b1, 1'b0, 4'b0011, 32'h40, 32'h0, 1'b1, 1'b0);
    #1;
    chk("midrst_jump_sel", 32'(bus.jump_sel), 32'd0);
    chk("midrst_mispredict", 32'(bus.mispredict), 32'd0);
    tick();
    rst_n = 1'b1;
    idle();
    exp_bc = '0; exp_mc = '0;
    check_counts("midrst");
    check_pred("midrst_pred_40", 32'h40, 1'b0);
    check_pred("midrst_pred_14", 32'h14, 1'b0);
    branch(4'b0011, 32'h40, 1'b1, 32'h0, 1'b0, 1'b1);
    check_pred("midrst_weak_init", 32'h40, 1'b1);
    check_counts("midrst_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
